// File: rtl/um_load_ctrl.sv
// ---------------------------------------------------------------------------
// um_load_ctrl -- load/sort sequencer for the unsorted memory (UM) bank.
//
// Accepts a valid/ready element stream and writes the elements into
// consecutive UM addresses. A short batch (s_last before the bank is full) is
// padded with PAD_VALUE up to the last address. One FLUSH cycle follows the
// final write, and then a single-cycle sort_start pulse is issued. While the
// sorter runs, UM address ownership goes to the sorter (um_addr = sort_addr)
// until sort_done, which reopens the controller for the next batch.
//
// Ports
//   clk_mn      in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   s_valid     in   input element valid
//   s_ready     out  controller accepts an element (LOAD state only)
//   s_data      in   input element
//   s_last      in   final element of the batch, qualified by the handshake
//   sort_addr   in   sorter's UM read address
//   sort_done   in   sorter finished, single-cycle pulse
//   um_valid    out  UM write enable
//   um_addr     out  UM address (sort_addr while sorting)
//   um_data     out  UM write data
//   sort_start  out  one-cycle start pulse to the sorter
//   valid_cnt   out  real (non-pad) elements in the current batch
//   busy        out  high in PAD, FLUSH and SORT
// ---------------------------------------------------------------------------
`ifndef ELEMENT_NUM
`define ELEMENT_NUM 8
`endif
`ifndef LOG2_ELEMENT_NUM
`define LOG2_ELEMENT_NUM 3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module um_load_ctrl #(
  parameter int                    ELEMENT_NUM      = `ELEMENT_NUM,
  parameter int                    LOG2_ELEMENT_NUM = `LOG2_ELEMENT_NUM,
  parameter int                    DATA_WIDTH       = `DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE        = '1
) (
  input  logic                        clk_mn,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_last,
  input  logic [LOG2_ELEMENT_NUM-1:0] sort_addr,
  input  logic                        sort_done,
  output logic                        um_valid,
  output logic [LOG2_ELEMENT_NUM-1:0] um_addr,
  output logic [DATA_WIDTH-1:0]       um_data,
  output logic                        sort_start,
  output logic [LOG2_ELEMENT_NUM:0]   valid_cnt,
  output logic                        busy
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_PAD   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_SORT  = 2'd3;

  localparam logic [LOG2_ELEMENT_NUM-1:0] LAST_ADDR = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);
  localparam logic [LOG2_ELEMENT_NUM-1:0] PTR_ONE   = LOG2_ELEMENT_NUM'(1);
  localparam logic [LOG2_ELEMENT_NUM:0]   CNT_ONE   = (LOG2_ELEMENT_NUM + 1)'(1);

  logic [1:0]                  state_q,      state_d;
  logic [LOG2_ELEMENT_NUM-1:0] wr_ptr_q,     wr_ptr_d;
  logic [LOG2_ELEMENT_NUM:0]   valid_cnt_q,  valid_cnt_d;
  logic                        um_valid_q,   um_valid_d;
  logic [LOG2_ELEMENT_NUM-1:0] um_addr_q,    um_addr_d;
  logic [DATA_WIDTH-1:0]       um_data_q,    um_data_d;
  logic                        sort_start_q, sort_start_d;

  // Handshake is qualified by the registered state only, so s_ready has no
  // combinational dependency on s_valid.
  assign s_ready = (state_q == ST_LOAD);
  assign busy    = (state_q != ST_LOAD);

  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    valid_cnt_d  = valid_cnt_q;
    um_valid_d   = 1'b0;
    um_addr_d    = um_addr_q;
    um_data_d    = um_data_q;
    sort_start_d = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          um_valid_d  = 1'b1;
          um_addr_d   = wr_ptr_q;
          um_data_d   = s_data;
          wr_ptr_d    = wr_ptr_q + PTR_ONE;
          valid_cnt_d = valid_cnt_q + CNT_ONE;
          // A full bank wins over s_last: no padding is needed then.
          if (wr_ptr_q == LAST_ADDR) state_d = ST_FLUSH;
          else if (s_last)           state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        um_valid_d = 1'b1;
        um_addr_d  = wr_ptr_q;
        um_data_d  = PAD_VALUE;
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        if (wr_ptr_q == LAST_ADDR) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // The final write is on the port this cycle; the sorter is started
        // only once it has been captured by the UM.
        state_d      = ST_SORT;
        sort_start_d = 1'b1;
      end
      default: begin // ST_SORT
        if (sort_done) begin
          state_d     = ST_LOAD;
          wr_ptr_d    = '0;
          valid_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_mn or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= '0;
      valid_cnt_q  <= '0;
      um_valid_q   <= 1'b0;
      um_addr_q    <= '0;
      um_data_q    <= '0;
      sort_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      valid_cnt_q  <= valid_cnt_d;
      um_valid_q   <= um_valid_d;
      um_addr_q    <= um_addr_d;
      um_data_q    <= um_data_d;
      sort_start_q <= sort_start_d;
    end
  end

  // While sorting, the sorter owns the UM address bus.
  assign um_addr    = (state_q == ST_SORT) ? sort_addr : um_addr_q;
  assign um_valid   = um_valid_q;
  assign um_data    = um_data_q;
  assign sort_start = sort_start_q;
  assign valid_cnt  = valid_cnt_q;

endmodule
